// File: rtl/cost_window_selector_if.sv
// Sample/result bundle for cost_window_selector: one sample in per valid cycle,
// one selected account out per full-window acceptance.
interface cost_window_selector_if #(
    parameter int DSIZE = 8,
    parameter int CNT_W = 12
);
    logic             in_valid;
    logic [DSIZE-1:0] in_account;
    logic [DSIZE-1:0] in_A;
    logic [DSIZE-1:0] in_T;
    logic             flush;
    logic             out_valid;
    logic [DSIZE-1:0] out_account;
    logic [CNT_W-1:0] out_cnt;

    modport master (
        output in_valid, in_account, in_A, in_T, flush,
        input  out_valid, out_account, out_cnt
    );

    modport slave (
        input  in_valid, in_account, in_A, in_T, flush,
        output out_valid, out_account, out_cnt
    );
endinterface

// File: rtl/cost_window_selector.sv
// Sliding 5-sample window of (account, A*T); emits the account with minimum cost,
// newest sample winning ties, one cycle after each acceptance that leaves the window full.
module cost_window_selector #(
    parameter int DSIZE = 8,
    parameter int CNT_W = 12
) (
    input  logic                   clk2,
    input  logic                   rst,
    cost_window_selector_if.slave  bus
);
    localparam int COST_W = 2 * DSIZE;
    localparam int DEPTH  = 5;

    typedef logic [DSIZE-1:0]  acct_t;
    typedef logic [COST_W-1:0] cost_t;

    function automatic cost_t calc_cost(input acct_t a, input acct_t t);
        return cost_t'(a) * cost_t'(t);
    endfunction

    // Window storage, index 0 oldest .. DEPTH-1 newest
    acct_t win_acct_q [DEPTH];
    acct_t win_acct_d [DEPTH];
    cost_t win_cost_q [DEPTH];
    cost_t win_cost_d [DEPTH];

    logic [2:0]       fill_q, fill_d;
    logic             vld_p0_q, vld_p0_d;
    logic             out_valid_q, out_valid_d;
    acct_t            out_account_q, out_account_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

    logic  accept;
    acct_t sel_acct;
    cost_t sel_cost;

    assign accept = bus.in_valid && !bus.flush;

    // Stage p0: shift the sample in and track fill
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            win_acct_d[i] = win_acct_q[i];
            win_cost_d[i] = win_cost_q[i];
        end
        fill_d   = fill_q;
        vld_p0_d = 1'b0;
        if (bus.flush) begin
            fill_d = 3'd0;
        end else if (bus.in_valid) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                win_acct_d[i] = win_acct_q[i+1];
                win_cost_d[i] = win_cost_q[i+1];
            end
            win_acct_d[DEPTH-1] = bus.in_account;
            win_cost_d[DEPTH-1] = calc_cost(bus.in_A, bus.in_T);
            if (fill_q != 3'd5) begin
                fill_d = fill_q + 3'd1;
            end
            vld_p0_d = (fill_q >= 3'd4);
        end
    end

    // Oldest-to-newest scan with <= lets the newest tied entry win
    always_comb begin
        sel_acct = win_acct_q[0];
        sel_cost = win_cost_q[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (win_cost_q[i] <= sel_cost) begin
                sel_acct = win_acct_q[i];
                sel_cost = win_cost_q[i];
            end
        end
    end

    // Stage p1: register the selected account and count results
    always_comb begin
        out_valid_d   = vld_p0_q;
        out_account_d = vld_p0_q ? sel_acct : out_account_q;
        out_cnt_d     = out_cnt_q + CNT_W'(vld_p0_q);
    end

    always_ff @(posedge clk2) begin
        if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_acct_q[i] <= win_acct_d[i];
                win_cost_q[i] <= win_cost_d[i];
            end
        end
    end

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            fill_q        <= 3'd0;
            vld_p0_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            out_account_q <= '0;
            out_cnt_q     <= '0;
        end else begin
            fill_q        <= fill_d;
            vld_p0_q      <= vld_p0_d;
            out_valid_q   <= out_valid_d;
            out_account_q <= out_account_d;
            out_cnt_q     <= out_cnt_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_account = out_account_q;
    assign bus.out_cnt     = out_cnt_q;
endmodule

// File: tb/tb_cost_window_selector.sv
// Directed and random stimulus for cost_window_selector against a reference
// sliding-minimum model plus hand-computed spot values.
module tb_cost_window_selector;
    localparam int DSIZE = 8;
    localparam int CNT_W = 12;

    logic clk2 = 1'b0;
    logic rst  = 1'b0;

    cost_window_selector_if #(.DSIZE(DSIZE), .CNT_W(CNT_W)) bus ();

    cost_window_selector #(.DSIZE(DSIZE), .CNT_W(CNT_W)) dut (
        .clk2 (clk2),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk2 = ~clk2;

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 is the newest sample
    int m_acct [5];
    int m_cost [5];
    int m_fill;
    bit pend;
    int pend_acct;
    bit e_vld;
    int e_acct;
    int e_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fill = 0;
        pend   = 0;
        e_vld  = 0;
        e_acct = 0;
        e_cnt  = 0;
    endtask

    function automatic int model_min();
        int b = 0;
        for (int i = 1; i < 5; i++)
            if (m_cost[i] < m_cost[b]) b = i;
        return m_acct[b];
    endfunction

    // Drive one cycle, advance the model across the edge, compare #1 after it
    task automatic step(input bit v, input int acct, input int a, input int t, input bit fl);
        bus.in_valid   = v;
        bus.in_account = v ? DSIZE'(acct) : 'x;
        bus.in_A       = v ? DSIZE'(a)    : 'x;
        bus.in_T       = v ? DSIZE'(t)    : 'x;
        bus.flush      = fl;
        @(posedge clk2);
        e_vld = pend;
        if (pend) begin
            e_acct = pend_acct;
            e_cnt  = (e_cnt + 1) % (1 << CNT_W);
        end
        pend = 0;
        if (fl) begin
            m_fill = 0;
        end else if (v) begin
            for (int i = 4; i > 0; i--) begin
                m_acct[i] = m_acct[i-1];
                m_cost[i] = m_cost[i-1];
            end
            m_acct[0] = acct;
            m_cost[0] = a * t;
            if (m_fill < 5) m_fill++;
            if (m_fill == 5) begin
                pend      = 1;
                pend_acct = model_min();
            end
        end
        #1;
        check_eq("out_valid", bus.out_valid, e_vld);
        check_eq("out_account", bus.out_account, e_acct);
        check_eq("out_cnt", bus.out_cnt, e_cnt);
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic do_flush();
        step(1'b0, 0, 0, 0, 1'b1);
    endtask

    initial begin
        int c0;
        int pa [5];
        int pt [5];
        bus.in_valid   = 1'b0;
        bus.in_account = '0;
        bus.in_A       = '0;
        bus.in_T       = '0;
        bus.flush      = 1'b0;
        model_reset();

        // Reset asserted before any clock edge must clear outputs on its own
        #1 rst = 1'b1;
        #2;
        check_eq("rst_async_valid", bus.out_valid, 0);
        check_eq("rst_async_acct", bus.out_account, 0);
        check_eq("rst_async_cnt", bus.out_cnt, 0);
        @(posedge clk2);
        @(posedge clk2);
        #1 rst = 1'b0;

        // Cost-0 oldest sample wins over four cost-1 samples
        step(1'b1, 10, 0, 0, 1'b0);
        for (int i = 1; i < 5; i++) step(1'b1, 10 + i, 1, 1, 1'b0);
        check_eq("r032_no_early", bus.out_valid, 0);
        idle();
        check_eq("r032_valid", bus.out_valid, 1);
        check_eq("r032_acct", bus.out_account, 10);
        check_eq("r032_cnt", bus.out_cnt, 1);
        idle();
        check_eq("r032_one_cycle", bus.out_valid, 0);
        check_eq("r032_hold", bus.out_account, 10);

        // All-equal costs: newest wins the tie
        do_flush();
        for (int i = 0; i < 5; i++) step(1'b1, 20 + i, 1, 1, 1'b0);
        idle();
        check_eq("r033_acct", bus.out_account, 24);
        check_eq("r033_cnt", bus.out_cnt, 2);

        // Large costs 65025/64770 with a cost-0 sample sliding through
        do_flush();
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 30 + i,
                 (i == 5) ? 0 : ((i % 2) ? 254 : 255),
                 (i == 5) ? 200 : 255, 1'b0);
            if (i == 5) check_eq("r034_pre_zero", bus.out_account, 33);
            if (i >= 6) check_eq("r034_zero_sel", bus.out_account, 35);
        end
        idle();
        check_eq("r034_post_zero", bus.out_account, 39);

        // Flush with a valid sample after six accepts
        do_flush();
        pa = '{9, 3, 8, 4, 7};
        pt = '{9, 5, 8, 4, 7};
        for (int i = 0; i < 5; i++) step(1'b1, 50 + i, pa[i], pt[i], 1'b0);
        step(1'b1, 55, 6, 6, 1'b0);
        c0 = int'(bus.out_cnt);
        step(1'b1, 99, 0, 0, 1'b1);
        check_eq("r037_inflight_valid", bus.out_valid, 1);
        check_eq("r037_inflight_acct", bus.out_account, 51);
        check_eq("r037_inflight_cnt", bus.out_cnt, (c0 + 1) % (1 << CNT_W));
        pa = '{2, 1, 3, 5, 4};
        pt = '{3, 5, 3, 1, 4};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 60 + i, pa[i], pt[i], 1'b0);
            check_eq("r037_refill_novld", bus.out_valid, 0);
        end
        idle();
        check_eq("r037_next_valid", bus.out_valid, 1);
        check_eq("r037_next_acct", bus.out_account, 63);

        // Asynchronous reset mid-stream, between clock edges
        do_flush();
        for (int i = 0; i < 3; i++) step(1'b1, 70 + i, 0, 5, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("r036_rst_valid", bus.out_valid, 0);
        check_eq("r036_rst_acct", bus.out_account, 0);
        check_eq("r036_rst_cnt", bus.out_cnt, 0);
        #1 rst = 1'b0;
        model_reset();
        pa = '{3, 2, 5, 6, 7};
        pt = '{3, 2, 5, 1, 7};
        for (int i = 0; i < 5; i++) step(1'b1, 80 + i, pa[i], pt[i], 1'b0);
        idle();
        check_eq("r036_valid", bus.out_valid, 1);
        check_eq("r036_acct", bus.out_account, 81);
        check_eq("r036_cnt", bus.out_cnt, 1);

        // Random stream with gaps, then run the counter past its wrap
        @(negedge clk2);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            int gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) idle();
            step(1'b1, $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), 1'b0);
        end
        idle();
        check_eq("r035_cnt", bus.out_cnt, 3996);
        for (int n = 0; n < 101; n++)
            step(1'b1, $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), 1'b0);
        idle();
        check_eq("cnt_wrap", bus.out_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
